// File: rtl/mc_result_collector.sv
// Collects per-path results from NCORES Monte Carlo cores and accumulates sum (and sum of squares).
// Optional macro MC_COLLECT_SUMSQ_EN builds the square stage; otherwise oSumSq is tied to 0.
module mc_result_collector #(
  parameter int NCORES = 4,
  parameter int ACCW   = 27,
  parameter int CNTW   = 16
) (
  input  logic                     CLK,
  input  logic                     iReset_n,
  input  logic                     iStart,
  input  logic [CNTW-1:0]          iPathTarget,
  input  logic [NCORES*ACCW-1:0]   iAcc,
  input  logic [NCORES-1:0]        iDone,
  input  logic                     iReady,
  output logic [ACCW+CNTW-1:0]     oSum,
  output logic [2*ACCW+CNTW-1:0]   oSumSq,
  output logic                     oValid,
  output logic                     oBusy,
  output logic                     oOverrun
);

  localparam int PW   = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int SUMW = ACCW + CNTW;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [ACCW-1:0]   cap_q [NCORES];
  logic [ACCW-1:0]   cap_d [NCORES];
  logic [NCORES-1:0] pend_q, pend_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [CNTW-1:0]   target_q, target_d;
  logic              overrun_q, overrun_d;
  logic [ACCW-1:0]   s1_q, s1_d;
  logic              s1Valid_q, s1Valid_d;
  logic [SUMW-1:0]   sum_q, sum_d;
  logic              drainCnt_q, drainCnt_d;

  logic              grantValid;
  logic [PW-1:0]     grantIdx;
  int unsigned       rrIdx;
  logic              accept;
  logic              lastAccept;

  // Round-robin search: first pending slot at or after the pointer, wrapping at NCORES.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    rrIdx      = 0;
    for (int k = 0; k < NCORES; k++) begin
      rrIdx = int'(ptr_q) + k;
      if (rrIdx >= NCORES) rrIdx = rrIdx - NCORES;
      if (!grantValid && pend_q[rrIdx]) begin
        grantValid = 1'b1;
        grantIdx   = PW'(rrIdx);
      end
    end
  end

  assign accept     = (state_q == COLLECT) && grantValid;
  assign lastAccept = accept && ((count_q + CNTW'(1)) == target_q);

  always_ff @(posedge CLK) begin
    if (!iReset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iStart) state_d = (iPathTarget == '0) ? DONE : COLLECT;
      COLLECT: if (lastAccept) state_d = DRAIN;
      DRAIN:   if (drainCnt_q) state_d = DONE;
      DONE:    if (iReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oValid   = (state_q == DONE);
    oBusy    = (state_q == COLLECT) || (state_q == DRAIN);
    oSum     = sum_q;
    oOverrun = overrun_q;
  end

  always_comb begin
    pend_d     = pend_q;
    cap_d      = cap_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    target_d   = target_q;
    overrun_d  = overrun_q;
    s1_d       = s1_q;
    s1Valid_d  = 1'b0;
    sum_d      = sum_q;
    drainCnt_d = (state_q == DRAIN) ? ~drainCnt_q : 1'b0;
    if (s1Valid_q) sum_d = sum_q + SUMW'(s1_q);
    if (state_q == COLLECT) begin
      // Freeing the accepted slot first lets it be recaptured this cycle without overrun.
      for (int i = 0; i < NCORES; i++) begin
        if (accept && (grantIdx == PW'(i))) pend_d[i] = 1'b0;
        if (iDone[i]) begin
          if (pend_d[i]) begin
            overrun_d = 1'b1;
          end else begin
            cap_d[i]  = iAcc[i*ACCW +: ACCW];
            pend_d[i] = 1'b1;
          end
        end
      end
      if (accept) begin
        s1_d      = cap_q[grantIdx];
        s1Valid_d = 1'b1;
        count_d   = count_q + CNTW'(1);
        ptr_d     = (grantIdx == PW'(NCORES-1)) ? '0 : grantIdx + PW'(1);
      end
      if (lastAccept) pend_d = '0;
    end
    if ((state_q == IDLE) && iStart) begin
      sum_d     = '0;
      count_d   = '0;
      overrun_d = 1'b0;
      target_d  = iPathTarget;
    end
  end

  always_ff @(posedge CLK) begin
    if (!iReset_n) begin
      cap_q      <= '{default: '0};
      pend_q     <= '0;
      ptr_q      <= '0;
      count_q    <= '0;
      target_q   <= '0;
      overrun_q  <= 1'b0;
      s1_q       <= '0;
      s1Valid_q  <= 1'b0;
      sum_q      <= '0;
      drainCnt_q <= 1'b0;
    end else begin
      cap_q      <= cap_d;
      pend_q     <= pend_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      target_q   <= target_d;
      overrun_q  <= overrun_d;
      s1_q       <= s1_d;
      s1Valid_q  <= s1Valid_d;
      sum_q      <= sum_d;
      drainCnt_q <= drainCnt_d;
    end
  end

`ifdef MC_COLLECT_SUMSQ_EN
  localparam int SQW  = 2 * ACCW;
  localparam int SSQW = 2 * ACCW + CNTW;

  logic [SQW-1:0]  sq_q, sq_d;
  logic            sqValid_q, sqValid_d;
  logic [SSQW-1:0] sumSq_q, sumSq_d;

  // Square stage trails the sum stage by one edge; DRAIN is sized to cover it.
  always_comb begin
    sq_d      = SQW'(s1_q) * SQW'(s1_q);
    sqValid_d = s1Valid_q;
    sumSq_d   = sumSq_q;
    if (sqValid_q) sumSq_d = sumSq_q + SSQW'(sq_q);
    if ((state_q == IDLE) && iStart) sumSq_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (!iReset_n) begin
      sq_q      <= '0;
      sqValid_q <= 1'b0;
      sumSq_q   <= '0;
    end else begin
      sq_q      <= sq_d;
      sqValid_q <= sqValid_d;
      sumSq_q   <= sumSq_d;
    end
  end

  assign oSumSq = sumSq_q;
`else
  assign oSumSq = '0;
`endif

endmodule

// File: tb/tb_mc_result_collector.sv
// Self-checking bench for mc_result_collector: directed runs with a scoreboard of expected totals.
module tb_mc_result_collector;

  localparam int NCORES = 4;
  localparam int ACCW   = 27;
  localparam int CNTW   = 16;

`ifdef MC_COLLECT_SUMSQ_EN
  localparam logic [127:0] SQ_EN = 128'd1;
`else
  localparam logic [127:0] SQ_EN = 128'd0;
`endif

  logic                   CLK = 1'b0;
  logic                   iReset_n = 1'b0;
  logic                   iStart = 1'b0;
  logic [CNTW-1:0]        iPathTarget = '0;
  logic [NCORES*ACCW-1:0] iAcc = '0;
  logic [NCORES-1:0]      iDone = '0;
  logic                   iReady = 1'b0;
  logic [ACCW+CNTW-1:0]   oSum;
  logic [2*ACCW+CNTW-1:0] oSumSq;
  logic                   oValid;
  logic                   oBusy;
  logic                   oOverrun;

  typedef struct {
    logic [127:0] sum;
    logic [127:0] sumSq;
    logic         overrun;
    int           latency;
  } exp_t;

  exp_t sbQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  mc_result_collector #(.NCORES(NCORES), .ACCW(ACCW), .CNTW(CNTW)) dut (
    .CLK(CLK), .iReset_n(iReset_n), .iStart(iStart), .iPathTarget(iPathTarget),
    .iAcc(iAcc), .iDone(iDone), .iReady(iReady), .oSum(oSum), .oSumSq(oSumSq),
    .oValid(oValid), .oBusy(oBusy), .oOverrun(oOverrun)
  );

  always #5 CLK = ~CLK;

  function automatic logic [127:0] sq(input logic [127:0] v);
    return v * v * SQ_EN;
  endfunction

  function automatic logic [NCORES*ACCW-1:0] packAcc(input int a, input int b, input int c, input int d);
    return {ACCW'(d), ACCW'(c), ACCW'(b), ACCW'(a)};
  endfunction

  task automatic checkVal(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    testsRun++;
    assert (observed === expected)
      else begin
        testsFailed++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic doReset();
    iReset_n = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    iReset_n = 1'b1;
  endtask

  task automatic startRun(input int target);
    iPathTarget = CNTW'(target);
    iStart = 1'b1;
    @(negedge CLK);
    iStart = 1'b0;
  endtask

  task automatic pulse(input logic [NCORES-1:0] mask, input logic [NCORES*ACCW-1:0] acc);
    iDone = mask;
    iAcc  = acc;
    @(negedge CLK);
    iDone = '0;
    iAcc  = '0;
  endtask

  // Pushes the expected outcome of a run and starts it.
  task automatic applyStimulus(input int target, input logic [127:0] expSum,
                               input logic [127:0] expSq, input logic expOv, input int lat);
    exp_t e;
    e.sum = expSum;
    e.sumSq = expSq;
    e.overrun = expOv;
    e.latency = lat;
    sbQ.push_back(e);
    startRun(target);
  endtask

  // Waits (bounded) for oValid, counting edges after the triggering edge, then checks and hands off.
  task automatic checkOutput(input string tag);
    exp_t e;
    int edges = 0;
    while (!oValid && edges < 40) begin
      @(negedge CLK);
      edges++;
    end
    e = sbQ.pop_front();
    checkVal({tag, "_valid"}, oValid, 1);
    checkVal({tag, "_latency"}, edges, e.latency);
    checkVal({tag, "_sum"}, oSum, e.sum);
    checkVal({tag, "_sumsq"}, oSumSq, e.sumSq);
    checkVal({tag, "_overrun"}, oOverrun, e.overrun);
    checkVal({tag, "_busy"}, oBusy, 0);
    iDone = '1;
    iAcc  = packAcc(77, 77, 77, 77);
    iStart = 1'b1;
    iPathTarget = CNTW'(5);
    @(negedge CLK);
    iDone = '0;
    iAcc  = '0;
    iStart = 1'b0;
    checkVal({tag, "_hold_valid"}, oValid, 1);
    checkVal({tag, "_hold_sum"}, oSum, e.sum);
    iReady = 1'b1;
    @(negedge CLK);
    iReady = 1'b0;
    checkVal({tag, "_ready_valid"}, oValid, 0);
    checkVal({tag, "_ready_sum"}, oSum, e.sum);
    checkVal({tag, "_ready_busy"}, oBusy, 0);
  endtask

  initial begin
    doReset();
    checkVal("reset_sum", oSum, 0);
    checkVal("reset_sumsq", oSumSq, 0);
    checkVal("reset_valid", oValid, 0);
    checkVal("reset_busy", oBusy, 0);
    checkVal("reset_overrun", oOverrun, 0);

    applyStimulus(1, 1000, sq(1000), 1'b0, 3);
    checkVal("single_busy", oBusy, 1);
    pulse(4'b0001, packAcc(1000, 0, 0, 0));
    checkOutput("single");

    doReset();
    applyStimulus(4, 10, sq(1) + sq(2) + sq(3) + sq(4), 1'b0, 6);
    pulse(4'b1111, packAcc(1, 2, 3, 4));
    checkOutput("simul");

    doReset();
    applyStimulus(2, 11, sq(5) + sq(6), 1'b0, 4);
    pulse(4'b1111, packAcc(5, 6, 7, 8));
    checkOutput("midbatch");

    doReset();
    applyStimulus(3, 16, sq(3) + sq(9) + sq(4), 1'b1, 3);
    pulse(4'b0011, packAcc(3, 9, 0, 0));
    pulse(4'b0010, packAcc(0, 7, 0, 0));
    checkVal("overrun_flag", oOverrun, 1);
    @(negedge CLK);
    @(negedge CLK);
    pulse(4'b0100, packAcc(0, 0, 4, 0));
    checkOutput("overrun");

    applyStimulus(0, 0, 0, 1'b0, 0);
    checkOutput("zero");

    doReset();
    startRun(5);
    pulse(4'b0011, packAcc(11, 22, 0, 0));
    doReset();
    checkVal("midreset_busy", oBusy, 0);
    checkVal("midreset_sum", oSum, 0);
    applyStimulus(1, 42, sq(42), 1'b0, 3);
    pulse(4'b0001, packAcc(42, 0, 0, 0));
    checkOutput("midreset");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
